// File: rtl/prog_dumper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prog_dumper
// Description : Reads a block of memory on clk and streams it as 8N1 UART
//               frames on uart_clk. Optional macro PROG_DUMPER_CHECKSUM_EN
//               appends a modulo-256 sum frame after the data.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_dumper #(
  parameter int BIT_TICKS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] length,
  output logic [20:0] adr,
  output logic        rd,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        done,
  input  logic        uart_clk,
  output logic        tx
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_READ  = 3'd1;
  localparam logic [2:0] c_S_WAIT  = 3'd2;
  localparam logic [2:0] c_S_LATCH = 3'd3;
  localparam logic [2:0] c_S_HAND  = 3'd4;
  localparam logic [2:0] c_S_FLUSH = 3'd5;
`ifdef PROG_DUMPER_CHECKSUM_EN
  localparam logic [2:0] c_S_CSUM  = 3'd6;
`endif

  localparam logic [1:0] c_U_IDLE  = 2'd0;
  localparam logic [1:0] c_U_START = 2'd1;
  localparam logic [1:0] c_U_DATA  = 2'd2;
  localparam logic [1:0] c_U_STOP  = 2'd3;
  localparam logic [3:0] c_TICK_LAST = 4'(BIT_TICKS - 1);

  // clk domain
  logic [2:0]  r_state, w_state_nxt;
  logic [20:0] r_adr, r_remaining;
  logic [7:0]  r_byte;
  logic        r_req_seq, r_done;
  logic        r_ack_meta, r_ack_sync, r_idle_meta, r_idle_sync;
  logic        w_acked, w_accept, w_latch, w_step, w_done_set;
`ifdef PROG_DUMPER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  // uart_clk domain
  logic [1:0]  r_u_state, w_u_state_nxt;
  logic        r_req_meta, r_req_sync, r_ack_seq, r_tx_idle;
  logic [3:0]  r_sub;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_pending, w_bit_end, w_load;

  assign adr     = r_adr;
  assign done    = r_done;
  assign tx      = r_tx;
  assign w_acked = (r_ack_sync == r_req_seq);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_meta  <= 1'b0;
      r_ack_sync  <= 1'b0;
      r_idle_meta <= 1'b0;
      r_idle_sync <= 1'b0;
    end else begin
      r_ack_meta  <= r_ack_seq;
      r_ack_sync  <= r_ack_meta;
      r_idle_meta <= r_tx_idle;
      r_idle_sync <= r_idle_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (start) begin
          if (length != 21'd0) w_state_nxt = c_S_READ;
`ifdef PROG_DUMPER_CHECKSUM_EN
          else                 w_state_nxt = c_S_CSUM;
`endif
        end
      end
      c_S_READ:  w_state_nxt = c_S_WAIT;
      c_S_WAIT:  w_state_nxt = c_S_LATCH;
      c_S_LATCH: w_state_nxt = c_S_HAND;
      c_S_HAND: begin
        if (w_acked) begin
          if (r_remaining != 21'd1) w_state_nxt = c_S_READ;
`ifdef PROG_DUMPER_CHECKSUM_EN
          else                      w_state_nxt = c_S_CSUM;
`else
          else                      w_state_nxt = c_S_FLUSH;
`endif
        end
      end
`ifdef PROG_DUMPER_CHECKSUM_EN
      c_S_CSUM:  w_state_nxt = c_S_FLUSH;
`endif
      c_S_FLUSH: if (w_acked && r_idle_sync) w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    rd         = (r_state == c_S_READ);
    busy       = (r_state != c_S_IDLE);
    w_accept   = (r_state == c_S_IDLE) && start && (length != 21'd0);
    w_latch    = (r_state == c_S_LATCH);
    w_step     = (r_state == c_S_HAND) && w_acked;
    w_done_set = (r_state == c_S_FLUSH) && w_acked && r_idle_sync;
`ifndef PROG_DUMPER_CHECKSUM_EN
    if ((r_state == c_S_IDLE) && start && (length == 21'd0)) w_done_set = 1'b1;
`endif
  end

  // r_byte stays put from LATCH until the serializer acks it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_adr       <= 21'd0;
      r_remaining <= 21'd0;
      r_byte      <= 8'd0;
      r_req_seq   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_accept) begin
        r_adr       <= 21'd0;
        r_remaining <= length;
      end else if (w_step) begin
        r_adr       <= r_adr + 21'd1;
        r_remaining <= r_remaining - 21'd1;
      end
      if (w_latch) begin
        r_byte    <= data;
        r_req_seq <= ~r_req_seq;
      end
`ifdef PROG_DUMPER_CHECKSUM_EN
      else if (r_state == c_S_CSUM) begin
        r_byte    <= r_sum;
        r_req_seq <= ~r_req_seq;
      end
`endif
    end
  end

`ifdef PROG_DUMPER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || ((r_state == c_S_IDLE) && start)) r_sum <= 8'd0;
    else if (w_latch)                              r_sum <= r_sum + data;
  end
`endif

  // ---------------- serializer (uart_clk) ----------------
  assign w_pending = (r_req_sync != r_ack_seq);
  assign w_bit_end = (r_sub == c_TICK_LAST);

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
    end else begin
      r_req_meta <= r_req_seq;
      r_req_sync <= r_req_meta;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset) r_u_state <= c_U_IDLE;
    else       r_u_state <= w_u_state_nxt;
  end

  always_comb begin
    w_u_state_nxt = r_u_state;
    case (r_u_state)
      c_U_IDLE:  if (w_pending) w_u_state_nxt = c_U_START;
      c_U_START: if (w_bit_end) w_u_state_nxt = c_U_DATA;
      c_U_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_u_state_nxt = c_U_STOP;
      c_U_STOP:  if (w_bit_end) w_u_state_nxt = w_pending ? c_U_START : c_U_IDLE;
      default:   w_u_state_nxt = c_U_IDLE;
    endcase
  end

  always_comb begin
    w_load = w_pending &&
             ((r_u_state == c_U_IDLE) || ((r_u_state == c_U_STOP) && w_bit_end));
  end

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_ack_seq <= 1'b0;
      r_sub     <= 4'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_tx_idle <= 1'b1;
    end else begin
      r_tx_idle <= (w_u_state_nxt == c_U_IDLE);
      if ((r_u_state == c_U_IDLE) || w_bit_end) r_sub <= 4'd0;
      else                                      r_sub <= r_sub + 4'd1;
      if (w_load) begin
        r_shift   <= r_byte;
        r_ack_seq <= ~r_ack_seq;
        r_tx      <= 1'b0;
        r_bit     <= 3'd0;
      end else if (w_bit_end) begin
        case (r_u_state)
          c_U_START: r_tx <= r_shift[0];
          c_U_DATA: begin
            if (r_bit == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
            end
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_dumper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prog_dumper
// Description : Scoreboard bench for prog_dumper: memory model, UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_dumper;

  localparam int BT    = 12;
  localparam int FRAME = 10 * BT;
`ifdef PROG_DUMPER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0, uart_clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [20:0] length = 21'd0;
  logic [20:0] adr;
  logic        rd, busy, done, tx;
  logic [7:0]  data = 8'hEE;

  prog_dumper #(.BIT_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .adr(adr), .rd(rd), .data(data), .busy(busy), .done(done),
    .uart_clk(uart_clk), .tx(tx)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #15 uart_clk = ~uart_clk;
  end

  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, rx_frames = 0, ucyc = 0;
  int rx_cnt = 0, rx_bitidx = 0;
  logic rx_active = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] mem [0:7];
  int exp_q[$];
  int adr_q[$];
  int fs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // memory: data valid for the whole cycle two cycles after rd
  initial begin
    logic s1v, s2v, s3v;
    logic [2:0] s1a, s2a, s3a;
    int e;
    s1v = 0; s2v = 0; s3v = 0; s1a = 0; s2a = 0; s3a = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        s1v = 0; s2v = 0; s3v = 0;
      end else begin
        s3v = s2v; s3a = s2a;
        s2v = s1v; s2a = s1a;
        s1v = rd;  s1a = adr[2:0];
        if (rd) begin
          e = (adr_q.size() != 0) ? adr_q.pop_front() : 32'hDEAD;
          check_eq("rd_adr", 32'(adr), 32'(e));
        end
      end
      data = s3v ? mem[s3a] : 8'hEE;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  // UART receiver, mid-bit sampling
  initial begin
    int k, e;
    forever begin
      @(negedge uart_clk);
      ucyc++;
      if (reset) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx == 1'b0) begin
          rx_active = 1'b1; rx_cnt = 0; rx_bitidx = 0;
          fs_q.push_back(ucyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == BT / 2) begin
          check_eq("rx_start_bit", 32'(tx), 32'd0);
        end else if (rx_cnt > BT / 2 && ((rx_cnt - BT / 2) % BT) == 0) begin
          k = (rx_cnt - BT / 2) / BT;
          if (k <= 8) begin
            rx_byte[k-1] = tx;
            rx_bitidx = k;
          end else begin
            check_eq("rx_stop_bit", 32'(tx), 32'd1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
            check_eq("rx_byte", 32'(rx_byte), 32'(e));
            rx_frames++;
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic start_dump(input int len);
    logic [7:0] s;
    s = 8'd0;
    @(negedge clk);
    start  = 1'b1;
    length = 21'(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(int'(mem[i]));
      adr_q.push_back(i);
      s = s + mem[i];
    end
`ifdef PROG_DUMPER_CHECKSUM_EN
    exp_q.push_back(int'(s));
`endif
    @(negedge clk);
    start  = 1'b0;
    length = 21'h1F0F0F;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0, n;
    c0 = done_cnt; n = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done_cnt - c0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0, busy_seen, hit, n;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (5) @(negedge uart_clk);
    @(negedge clk);
    check_eq("reset_tx",   32'(tx),   32'd1);
    check_eq("reset_adr",  32'(adr),  32'd0);
    check_eq("reset_rd",   32'(rd),   32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // single byte 0xA5
    mem[0] = 8'hA5;
    f0 = rx_frames;
    start_dump(1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 3000);
    check_eq("t1_busy_clr", 32'(busy), 32'd0);
    check_eq("t1_frames", 32'(rx_frames - f0), 32'(1 + CS));
    check_eq("t1_rd_left", 32'(adr_q.size()), 32'd0);

    // four bytes back to back
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55; mem[3] = 8'h3C;
    f0 = rx_frames;
    fs_q.delete();
    start_dump(4);
    wait_done("t2_done", 6000);
    check_eq("t2_frames", 32'(rx_frames - f0), 32'(4 + CS));
    check_eq("t2_queue", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < fs_q.size(); i++)
      check_eq("t2_gap", 32'(fs_q[i] - fs_q[i-1]), 32'(FRAME));

    // zero length
    f0 = rx_frames; d0 = done_cnt; busy_seen = 0;
    start_dump(0);
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
`ifdef PROG_DUMPER_CHECKSUM_EN
    wait_done("t3_done", 3000);
`else
    check_eq("t3_busy", 32'(busy_seen), 32'd0);
    check_eq("t3_done", 32'(done_cnt - d0), 32'd1);
`endif
    repeat (500) @(negedge clk);
    check_eq("t3_frames", 32'(rx_frames - f0), 32'(CS));

    // start while busy is ignored
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    f0 = rx_frames;
    start_dump(3);
    repeat (40) @(negedge clk);
    start = 1'b1; length = 21'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done", 6000);
    d0 = done_cnt;
    repeat (800) @(negedge clk);
    check_eq("t4_done_once", 32'(done_cnt), 32'(d0));
    check_eq("t4_frames", 32'(rx_frames - f0), 32'(3 + CS));
    check_eq("t4_queue", 32'(exp_q.size()), 32'd0);

    // reset during bit 3 of the second frame
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h81; mem[3] = 8'h7E;
    f0 = rx_frames;
    start_dump(4);
    hit = 0; n = 0;
    while (!hit && n < 4000) begin
      @(negedge clk);
      n++;
      if (rx_frames == f0 + 1 && rx_active && rx_bitidx == 4) hit = 1;
    end
    check_eq("t5_reach_bit3", 32'(hit), 32'd1);
    check_eq("t5_tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    @(posedge uart_clk);
    #1;
    check_eq("t5_tx_reset", 32'(tx), 32'd1);
    repeat (4) @(negedge uart_clk);
    @(negedge clk);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_adr",  32'(adr),  32'd0);
    exp_q.delete();
    adr_q.delete();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    mem[0] = 8'h96; mem[1] = 8'h0F;
    f0 = rx_frames;
    start_dump(2);
    wait_done("t5_done", 6000);
    check_eq("t5_frames", 32'(rx_frames - f0), 32'(2 + CS));
    check_eq("t5_queue", 32'(exp_q.size()), 32'd0);
    check_eq("t5_rd_left", 32'(adr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
